// File: rtl/serial_add_accum.sv
// serial_add_accum: bit-serial adder/subtractor, LSB-first through one full-adder
// cell and a carry flop. Result, carry-out and signed overflow are held until the
// next completion.
// Optional feature macro: SERIAL_ADD_ACCUM_EN (acc=1 loads operand A from sum).
module serial_add_accum #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             acc,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] opa_load_c;
   logic             bit_s_c;
   logic             bit_c_c;

`ifdef SERIAL_ADD_ACCUM_EN
   // Operand A source: running accumulator or port a
   assign opa_load_c = acc ? sum_q : a;
`else
   logic unused_acc;
   assign opa_load_c = a;
   assign unused_acc = acc;
`endif

   // Single full-adder cell on the current LSBs and the carry flop
   assign bit_s_c = opa_q[0] ^ opb_q[0] ^ c_q;
   assign bit_c_c = (opa_q[0] & opb_q[0]) | (opa_q[0] & c_q) | (opb_q[0] & c_q);

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (start) begin
               state_d = RUN;
               busy_d  = 1'b1;
               opa_d   = opa_load_c;
               opb_d   = sub ? ~b : b;
               c_d     = sub;
               cnt_d   = '0;
            end
         end
         RUN: begin
            opa_d = {1'b0, opa_q[WIDTH-1:1]};
            opb_d = {1'b0, opb_q[WIDTH-1:1]};
            res_d = {bit_s_c, res_q[WIDTH-1:1]};
            c_d   = bit_c_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               sum_d   = {bit_s_c, res_q[WIDTH-1:1]};
               carry_d = bit_c_c;
               // c_q here is the carry into the MSB
               ovf_d   = c_q ^ bit_c_c;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign sum       = sum_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;

endmodule
